// File: rtl/dbg_pkg.sv
// dbg_pkg: state encoding and command codes shared by the debug controller.
package dbg_pkg;
    typedef enum logic [2:0] {
        DBG_IDLE,
        DBG_LOAD,
        DBG_RUN,
        DBG_DUMP_REG,
        DBG_DUMP_MEM
    } dbg_state_e;
    localparam logic [1:0] DBG_CMD_LOAD = 2'd0;
    localparam logic [1:0] DBG_CMD_RUN  = 2'd1;
    localparam logic [1:0] DBG_CMD_DUMP = 2'd2;
    localparam logic [1:0] DBG_CMD_NOP  = 2'd3;
endpackage

// File: rtl/dbg_out_reg.sv
// dbg_out_reg: stall-holding dump output register; a word loads only while empty
// and is held until the sink takes it, giving one word per two cycles.
module dbg_out_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o
);
    logic         valid_q, valid_d, last_q, last_d;
    logic [W-1:0] data_q, data_d;
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else if (!valid_q && load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = valid_q & last_q;
endmodule

// File: rtl/dbg_ctrl.sv
// dbg_ctrl: debug controller for the RV32I core (imem load, bounded run, state dump).
// Define DBG_MEM_DUMP_EN to append a data-memory window to the register dump.
module dbg_ctrl
    import dbg_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int IMEM_AW    = 8,
    parameter int DUMP_WORDS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [XLEN-1:0]    cmd_arg,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [XLEN-1:0]    load_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               cpu_halt,
    output logic [4:0]         reg_raddr,
    input  logic [XLEN-1:0]    reg_rdata,
    output logic [31:0]        dmem_raddr,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [XLEN-1:0]    dump_data,
    output logic               dump_last,
    output logic               busy
);
    dbg_state_e         state_q, state_d, reg_next;
    logic [XLEN-1:0]    cnt_q, cnt_d, pres_data;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic               hs, pres, pres_last, reg_last;
    // cnt_q is the remaining count in LOAD/RUN and the word index while dumping
    assign hs         = dump_valid & dump_ready;
    assign cmd_ready  = state_q == DBG_IDLE;
    assign busy       = !cmd_ready;
    assign load_ready = state_q == DBG_LOAD && cnt_q != '0;
    assign imem_we    = load_valid & load_ready;
    assign imem_addr  = addr_q;
    assign imem_wdata = imem_we ? load_data : '0;
    assign cpu_halt   = !(state_q == DBG_RUN && cnt_q != '0);
    assign reg_raddr  = state_q == DBG_DUMP_REG ? 5'(cnt_q) : '0;
    assign reg_last   = cnt_q == XLEN'(NREG - 1);
    assign pres       = (state_q == DBG_DUMP_REG || state_q == DBG_DUMP_MEM) && !dump_valid;
`ifdef DBG_MEM_DUMP_EN
    logic mem_last;
    assign mem_last   = cnt_q == XLEN'(DUMP_WORDS - 1);
    assign reg_next   = DBG_DUMP_MEM;
    assign dmem_raddr = state_q == DBG_DUMP_MEM ? 32'(cnt_q) << 2 : '0;
    assign pres_data  = state_q == DBG_DUMP_MEM ? dmem_rdata : reg_rdata;
    assign pres_last  = state_q == DBG_DUMP_MEM && mem_last;
`else
    logic unused_dmem;
    assign unused_dmem = ^dmem_rdata;
    assign reg_next    = DBG_IDLE;
    assign dmem_raddr  = '0;
    assign pres_data   = reg_rdata;
    assign pres_last   = reg_last;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            DBG_IDLE: if (cmd_valid) begin
                cnt_d   = cmd_op == DBG_CMD_DUMP ? '0 : cmd_arg;
                addr_d  = cmd_op == DBG_CMD_LOAD ? '0 : addr_q;
                state_d = cmd_op == DBG_CMD_LOAD ? DBG_LOAD :
                          cmd_op == DBG_CMD_RUN  ? DBG_RUN  :
                          cmd_op == DBG_CMD_DUMP ? DBG_DUMP_REG : DBG_IDLE;
            end
            DBG_LOAD: begin
                cnt_d   = imem_we ? cnt_q - XLEN'(1) : cnt_q;
                addr_d  = imem_we ? addr_q + IMEM_AW'(1) : addr_q;
                state_d = cnt_q == '0 || (imem_we && cnt_q == XLEN'(1)) ? DBG_IDLE : state_q;
            end
            DBG_RUN: begin
                cnt_d   = cnt_q == '0 ? '0 : cnt_q - XLEN'(1);
                state_d = cnt_q <= XLEN'(1) ? DBG_IDLE : state_q;
            end
            DBG_DUMP_REG: if (hs) begin
                cnt_d   = reg_last ? '0 : cnt_q + XLEN'(1);
                state_d = reg_last ? reg_next : state_q;
            end
`ifdef DBG_MEM_DUMP_EN
            DBG_DUMP_MEM: if (hs) begin
                cnt_d   = cnt_q + XLEN'(1);
                state_d = mem_last ? DBG_IDLE : state_q;
            end
`endif
            default: state_d = DBG_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DBG_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end
    dbg_out_reg #(.W(XLEN)) u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pres),
        .data_i  (pres_data),
        .last_i  (pres_last),
        .ready_i (dump_ready),
        .valid_o (dump_valid),
        .data_o  (dump_data),
        .last_o  (dump_last)
    );
endmodule

// File: tb/tb_dbg_ctrl.sv
// tb_dbg_ctrl: scoreboard bench for dbg_ctrl; the bench models the register file and
// data memory as arrays and predicts imem writes, unhalted cycles and dump streams.
module tb_dbg_ctrl;
    import dbg_pkg::*;
    localparam int NREG = 32;
    localparam int DW   = 8;
`ifdef DBG_MEM_DUMP_EN
    localparam int NW = NREG + DW;
`else
    localparam int NW = NREG;
`endif
    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready;
    logic [1:0]  cmd_op = DBG_CMD_NOP;
    logic [31:0] cmd_arg = 0;
    logic        load_valid = 0, load_ready;
    logic [31:0] load_data = 0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_halt;
    logic [4:0]  reg_raddr;
    logic [31:0] reg_rdata, dmem_raddr, dmem_rdata;
    logic        dump_valid, dump_ready = 0, dump_last, busy;
    logic [31:0] dump_data;
    logic [31:0] regs [NREG];
    logic [31:0] mem [DW];
    logic [32:0] exp_q [$];
    logic [39:0] exp_imem [$];
    logic [31:0] lw_q [$];
    logic [32:0] me;
    logic [39:0] mi;
    logic [31:0] held_d;
    logic        held_l, stall_prev = 0, prev_low = 0;
    logic [3:0]  pat = 4'b1001;
    int          cmp = 0, fail = 0, rx_cnt = 0, unhalt = 0, falls = 0, rmode = 2, pk = 0;

    dbg_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_halt(cpu_halt),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_last(dump_last), .busy(busy)
    );

    always #5 clk = ~clk;
    assign reg_rdata  = regs[reg_raddr];
    assign dmem_rdata = mem[dmem_raddr[4:2]];

    always @(posedge clk) begin
        #1;
        if (rmode == 0) dump_ready = 1'b1;
        else if (rmode == 1) begin
            dump_ready = pat[pk];
            pk = (pk + 1) % 4;
        end else dump_ready = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
            prev_low = 0;
        end else begin
            if (imem_we) begin
                cmp++;
                if (exp_imem.size() == 0) begin
                    fail++;
                    $display("FAIL imem_extra got addr=%h data=%h want no write", imem_addr, imem_wdata);
                end else begin
                    mi = exp_imem.pop_front();
                    if ({imem_addr, imem_wdata} !== mi) begin
                        fail++;
                        $display("FAIL imem_write got addr=%h data=%h want addr=%h data=%h", imem_addr, imem_wdata, mi[39:32], mi[31:0]);
                    end
                end
            end
            if (!cpu_halt) begin
                unhalt++;
                if (!prev_low) falls++;
                cmp++;
                if (!busy) begin fail++; $display("FAIL run_busy got busy=0 want 1"); end
            end
            if (cpu_halt && prev_low) begin
                cmp++;
                if (busy) begin fail++; $display("FAIL run_busy_fall got busy=1 want 0"); end
            end
            prev_low = !cpu_halt;
            cmp++;
            if (dump_last && !dump_valid) begin fail++; $display("FAIL last_no_valid got last=1 valid=0 want last=0"); end
            if (stall_prev) begin
                cmp++;
                if (!dump_valid || dump_data !== held_d || dump_last !== held_l) begin
                    fail++;
                    $display("FAIL dump_hold got v=%b d=%h l=%b want v=1 d=%h l=%b", dump_valid, dump_data, dump_last, held_d, held_l);
                end
            end
`ifndef DBG_MEM_DUMP_EN
            if (dump_valid) begin
                cmp++;
                if (dmem_raddr !== 0) begin fail++; $display("FAIL dmem_tied got %h want 0", dmem_raddr); end
            end
`endif
            if (dump_valid && dump_ready) begin
                rx_cnt++;
                cmp++;
                if (exp_q.size() == 0) begin
                    fail++;
                    $display("FAIL dump_extra got d=%h l=%b want none", dump_data, dump_last);
                end else begin
                    me = exp_q.pop_front();
                    if ({dump_last, dump_data} !== me) begin
                        fail++;
                        $display("FAIL dump_word%0d got l=%b d=%h want l=%b d=%h", rx_cnt - 1, dump_last, dump_data, me[32], me[31:0]);
                    end
                end
            end
            stall_prev = dump_valid && !dump_ready;
            held_d = dump_data;
            held_l = dump_last;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        cmp++;
        if (got !== want) begin
            fail++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (busy && k < 3000) begin @(posedge clk); #1; k++; end
        chk(nm, 32'(busy), 0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [31:0] arg);
        int k = 0;
        while (!cmd_ready && k < 3000) begin @(posedge clk); #1; k++; end
        chk("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_op = op; cmd_arg = arg;
        @(posedge clk); #1;
        cmd_valid = 0; cmd_op = DBG_CMD_NOP; cmd_arg = $urandom;
    endtask

    task automatic load_seq(input int stall_at, input bit early);
        int n = lw_q.size();
        for (int i = 0; i < n; i++) exp_imem.push_back({8'(i), lw_q[i]});
        if (early && n > 0) begin load_valid = 1; load_data = lw_q[0]; end
        do_cmd(DBG_CMD_LOAD, 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin load_valid = 0; load_data = $urandom; @(posedge clk); #1; end
            load_valid = 1; load_data = lw_q[i];
            @(posedge clk); #1;
        end
        load_valid = 0;
        wait_idle("load_idle");
        chk("load_pending", 32'(exp_imem.size()), 0);
    endtask

    task automatic do_run(input int n);
        unhalt = 0; falls = 0;
        do_cmd(DBG_CMD_RUN, 32'(n));
        chk("run_start_halt", 32'(cpu_halt), 32'(n == 0));
        repeat (n + 4) @(posedge clk);
        #1;
        chk("run_len", 32'(unhalt), 32'(n));
        chk("run_contig", 32'(falls), 32'(n > 0));
        chk("run_done_busy", 32'(busy), 0);
    endtask

    task automatic do_dump(input int mode, input bit partial);
        int k = 0;
        for (int i = 0; i < NREG; i++) exp_q.push_back({1'(i == NW - 1), regs[i]});
`ifdef DBG_MEM_DUMP_EN
        for (int i = 0; i < DW; i++) exp_q.push_back({1'(NREG + i == NW - 1), mem[i]});
`endif
        rx_cnt = 0; rmode = mode; pk = 0;
        do_cmd(DBG_CMD_DUMP, $urandom);
        chk("dump_lat1", 32'(dump_valid), 0);
        @(posedge clk); #1;
        chk("dump_lat2", 32'(dump_valid), 1);
        if (partial) begin
            while (rx_cnt < 10 && k < 3000) begin @(posedge clk); #1; k++; end
            chk("partial_cnt", 32'(rx_cnt), 10);
            rst = 1; #1;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_valid", 32'(dump_valid), 0);
            chk("rst_cmd_ready", 32'(cmd_ready), 1);
            chk("rst_halt", 32'(cpu_halt), 1);
            exp_q.delete();
            @(posedge clk); #1;
            rst = 0;
        end else begin
            wait_idle("dump_idle");
            chk("dump_count", 32'(rx_cnt), 32'(NW));
            chk("dump_pending", 32'(exp_q.size()), 0);
        end
        rmode = 2;
    endtask

    task automatic rand_state();
        regs[0] = 0;
        for (int i = 1; i < NREG; i++) regs[i] = $urandom;
        for (int i = 0; i < DW; i++) mem[i] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rand_state();
        repeat (3) @(posedge clk);
        #1; rst = 0;
        chk("rst_cpu_halt", 32'(cpu_halt), 1);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_load_ready", 32'(load_ready), 0);
        chk("rst_imem_we", 32'(imem_we), 0);
        chk("rst_imem_addr", 32'(imem_addr), 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_dump_valid", 32'(dump_valid), 0);
        chk("rst_dump_data", dump_data, 0);
        chk("rst_dump_last", 32'(dump_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_reg_raddr", 32'(reg_raddr), 0);
        chk("rst_dmem_raddr", dmem_raddr, 0);
        lw_q = '{32'h00000093, 32'h00100113, 32'h002081B3, 32'h00000013};
        load_seq(3, 0);
        load_valid = 1; load_data = $urandom;
        do_cmd(DBG_CMD_LOAD, 0);
        @(posedge clk); #1;
        chk("load0_idle", 32'(busy), 0);
        load_valid = 0;
        lw_q.delete();
        for (int i = 0; i < 258; i++) lw_q.push_back($urandom);
        load_seq(100, 1);
        do_run(5);
        do_run(0);
        regs[1] = 32'hDEADBEEF;
        mem[0] = 32'h12345678;
        do_dump(1, 0);
        do_dump(2, 1);
        do_dump(0, 0);
        do_cmd(DBG_CMD_NOP, $urandom);
        chk("nop_busy", 32'(busy), 0);
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    lw_q.delete();
                    for (int i = 0; i < int'($urandom_range(1, 6)); i++) lw_q.push_back($urandom);
                    load_seq(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
                end
                1: do_run(int'($urandom_range(0, 7)));
                2: begin rand_state(); do_dump(2, 0); end
                default: begin
                    do_cmd(DBG_CMD_NOP, $urandom);
                    chk("nop_rand_busy", 32'(busy), 0);
                end
            endcase
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end
endmodule

// File: doc/dbg_ctrl.md
# dbg_ctrl

Debug controller for the single-cycle RV32I core that replaces testbench-only program loading and register/memory peeking with synthesizable logic. It loads instruction memory from a word stream, runs the core for a bounded number of cycles, then streams the register file and, optionally, a data-memory window out over a valid/ready channel. It sits beside `cpu` and drives the core's halt input, the instruction-memory write port, and spare read ports on the register file and data memory.

## Interface
- `XLEN`, default 32: data word width.
- `NREG`, default 32: number of registers dumped (x0..x(NREG-1)).
- `IMEM_AW`, default 8: instruction-memory word-address width.
- `DUMP_WORDS`, default 8: number of data-memory words dumped, starting at word 0.
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_op` in 2: command code. 0 = LOAD, 1 = RUN, 2 = DUMP, 3 = NOP.
- `cmd_arg` in XLEN: word count for LOAD; cycle count for RUN.
- `load_valid` in 1: load word offered.
- `load_ready` out 1: load word accepted.
- `load_data` in XLEN: instruction word.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_addr` out IMEM_AW: instruction-memory write word address.
- `imem_wdata` out XLEN: instruction-memory write data.
- `cpu_halt` out 1: when high, the core holds its PC and suppresses all writes.
- `reg_raddr` out 5: debug read address to the register file (asynchronous read).
- `reg_rdata` in XLEN: debug read data from the register file.
- `dmem_raddr` out 32: debug byte address to the data memory.
- `dmem_rdata` in XLEN: debug read data from the data memory.
- `dump_valid` out 1: dump word presented.
- `dump_ready` in 1: sink accepts the dump word.
- `dump_data` out XLEN: dump word.
- `dump_last` out 1: marks the final word of a dump.
- `busy` out 1: high whenever the controller is not in IDLE.

## Operation
- States: IDLE, LOAD, RUN, DUMP_REG, DUMP_MEM.
- `cmd_ready` equals 1 only in IDLE.
- **LOAD**
  - Resets the address counter to 0 and latches `cmd_arg` as the remaining count.
  - `load_ready` equals 1 in LOAD.
  - `imem_we` is the combinational AND of `load_valid` and `load_ready`. On that cycle, `imem_addr` equals the counter and `imem_wdata` equals `load_data`.
  - After each write, the counter increments and the remaining count decrements. The address wraps modulo 2^IMEM_AW.
  - When the remaining count reaches 0, the next state is IDLE.
  - A LOAD with `cmd_arg` = 0 returns to IDLE on the next cycle with no writes.
- **RUN**
  - `cpu_halt` is 0 for exactly `cmd_arg` consecutive cycles, starting the cycle after acceptance, and is 1 otherwise.
  - A RUN with `cmd_arg` = 0 returns to IDLE with no unhalted cycle.
- **DUMP**
  - An index counter starts at 0.
  - DUMP_REG: drives `reg_raddr` = index and registers `reg_rdata` into `dump_data`.
  - DUMP_MEM: drives `dmem_raddr` = 4·index and registers `dmem_rdata` into `dump_data`.
  - Transitions to DUMP_MEM after NREG register words, then to IDLE after DUMP_WORDS memory words.
- **NOP**: accepted with no effect; the state stays IDLE.
- `cpu_halt` stays 1 in every state except the unhalted RUN cycles.
- **Reset**: takes effect at any time, mid-LOAD, mid-RUN, or mid-DUMP. The state returns to IDLE and all counters clear.
- **Reset values**:
  - `cpu_halt` = 1, `cmd_ready` = 1.
  - `load_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `dump_valid` = 0, `dump_data` = 0, `dump_last` = 0, `busy` = 0.
  - `reg_raddr` = 0, `dmem_raddr` = 0.

## Timing
- Command acceptance: the state changes on the clock edge where `cmd_valid` and `cmd_ready` are both high.
- Dump latency: the first `dump_valid` is asserted 2 cycles after acceptance (one cycle to address, one to register).
- Dump handshake:
  - `dump_data` and `dump_last` are held stable while `dump_valid` is high and `dump_ready` is low.
  - A new word loads on the cycle after a handshake.
  - Sustained throughput is one word per 2 cycles.
- `dump_last` is high only together with `dump_valid` on the final word. After that handshake, the next state is IDLE, `dump_valid` drops, and `cmd_ready` rises on the following cycle.
- RUN: `busy` falls in the same cycle that `cpu_halt` returns to 1.
- Simultaneous events: a `load_valid` arriving in the cycle of LOAD acceptance is not consumed, because `load_ready` is still 0 in that cycle.

## Configuration
- Macro: `DBG_MEM_DUMP_EN`.
- Defined: the dump comprises NREG register words followed by DUMP_WORDS data-memory words.
- Undefined:
  - The DUMP_MEM state and its logic are removed.
  - `dump_last` accompanies register NREG-1.
  - `dmem_raddr` is tied to 0 and `dmem_rdata` is ignored.

## Structure
- Shared package `dbg_pkg` holds:
  - the state encoding (`DBG_IDLE`, `DBG_LOAD`, `DBG_RUN`, `DBG_DUMP_REG`, `DBG_DUMP_MEM`);
  - the command codes (`DBG_CMD_LOAD`, `DBG_CMD_RUN`, `DBG_CMD_DUMP`, `DBG_CMD_NOP`).
- Sub-module `dbg_out_reg` implements the stall-holding output register (`dump_data`, `dump_valid`, `dump_last`), so the FSM only presents words and watches the handshake.

## Test plan
- **Reset values**: hold `rst` for 3 cycles, then release → every output at its reset value and `cpu_halt` = 1.
- **LOAD**: LOAD `cmd_arg` = 4 with words 0x00000093, 0x00100113, 0x002081B3, 0x00000013, one stalled cycle before word 3 → `imem_we` pulses at addresses 0..3 with matching data, then IDLE. Repeat with LOAD 0 → IDLE one cycle later with no writes.
- **RUN**: RUN `cmd_arg` = 5 → `cpu_halt` low for exactly 5 cycles. RUN 0 → `cpu_halt` never low.
- **DUMP with back-pressure**: preload x1 = 0xDEADBEEF and mem word 0 = 0x12345678, then DUMP with `dump_ready` toggled 1,0,0,1 → word 1 = 0xDEADBEEF, word 32 = 0x12345678, `dump_last` on word 39, 40 words total, data stable during stalls.
- **Reset mid-dump**: assert `rst` after the 10th dump word → immediate IDLE. A fresh DUMP then restarts from x0.
- **Macro undefined**: DUMP → 32 words, `dump_last` on word 31, `dmem_raddr` constant 0.
